ps2_frame_rx: RTL

Upstream PS/2 keyboard receiver that feeds the calculator FSM.
- Synchronises and filters the raw keyboard clock and data lines, and deframes 11-bit device-to-host frames.
- Checks parity and stop bit, and folds the E0 (extended) and F0 (break) prefixes into flags.
- Presents one clean scan code per key event as a one-cycle strobe, so the consumer never sees partial frames or prefix bytes.

---
 rtl/ps2_frame_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and filters the raw lines, deframes
// 11-bit frames, folds E0/F0 prefixes into flags and strobes one clean scan code per key event.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 6,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);

    localparam int HALF = FILTER_LEN / 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  fall_pulse;
    logic                  data_bit;

    logic [1:0]       state;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift;
    logic [CNT_W-1:0] tcnt;
    logic             ext_pend;
    logic             brk_pend;
    logic             frame_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], keyb_clk};
            data_sync <= {data_sync[0], keyb_data};
            filt      <= {clk_sync[1], filt[FILTER_LEN-1:1]};
        end
    end

    // Newest sample sits at the MSB, so a settled low half above a settled high half is a clean fall.
    assign fall_pulse = (filt[FILTER_LEN-1:HALF] == '0) && (filt[HALF-1:0] == '1);
    assign data_bit   = data_sync[1];

    // shift[7:0] = data (LSB first), shift[8] = parity, shift[9] = stop
    assign frame_ok = (^shift[8:0]) & shift[9];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tcnt       <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            scan_code  <= 8'h00;
            code_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_pulse && !data_bit) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                    end
                end
                RECV: begin
                    if (fall_pulse) begin
                        shift   <= {data_bit, shift[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        tcnt    <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end
                    end else if (tcnt == TIMEOUT_VAL) begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else if (shift[7:0] == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (shift[7:0] == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        scan_code  <= shift[7:0];
                        code_valid <= 1'b1;
                        is_break   <= brk_pend;
                        is_ext     <= ext_pend;
                        ext_pend   <= 1'b0;
                        brk_pend   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
